// File: rtl/fpga_conf_ctrl.sv
// FPGA configuration controller: oversampled SPI command receiver with
// glitch-free major-mode sequencing (quiet guard interval before commit).
module fpga_conf_ctrl #(
    parameter int GUARD_CYCLES = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic [7:0] conf_word,
    output logic [2:0] major_mode,
    output logic [7:0] divisor,
    output logic       mode_quiet,
    output logic       busy,
    output logic       cmd_err
);

    localparam logic [7:0] CONF_RST   = 8'hE0;
    localparam logic [3:0] OP_CONF    = 4'b0001;
    localparam logic [3:0] OP_DIV     = 4'b0010;
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [4:0] BITS_FULL  = 5'd16;
    localparam logic [4:0] BITS_SAT   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUIET  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] spck_sync_q, spck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   spck_prev_q, spck_prev_d;
    logic                   ncs_prev_q,  ncs_prev_d;
    logic                   spck_s, mosi_s, ncs_s;
    logic                   spck_rise, ncs_fall, ncs_rise;

    always_comb begin
        spck_sync_d = {spck_sync_q[SYNC_STAGES-2:0], spck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
        spck_prev_d = spck_s;
        ncs_prev_d  = ncs_s;
    end

    assign spck_s    = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;

    // ncs resets high so a released reset never fakes a frame start
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            spck_sync_q <= spck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            spck_prev_q <= spck_prev_d;
            ncs_prev_q  <= ncs_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame shift register and bit counter
    // ------------------------------------------------------------------
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        shift_en;
    logic        frame_ok, frame_bad;
    logic        cfg_req, div_req;
    logic [7:0]  req_data;
    logic        unused_bits;

    assign shift_en = spck_rise & ~ncs_s;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (shift_en) begin
            shift_d = {shift_q[14:0], mosi_s};
        end
        if (ncs_fall) begin
            bit_cnt_d = spck_rise ? 5'd1 : 5'd0;
        end else if (shift_en && bit_cnt_q != BITS_SAT) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end
    end

    assign frame_ok    = ncs_rise && (bit_cnt_q == BITS_FULL);
    assign frame_bad   = ncs_rise && (bit_cnt_q != BITS_FULL);
    assign cfg_req     = frame_ok && (shift_q[15:12] == OP_CONF);
    assign div_req     = frame_ok && (shift_q[15:12] == OP_DIV);
    assign req_data    = shift_q[7:0];
    // Bits [11:8] carry no meaning for either command
    assign unused_bits = ^shift_q[11:8];

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Divisor register and error pulse
    // ------------------------------------------------------------------
    logic [7:0] div_q, div_d;
    logic       err_q, err_d;

    always_comb begin
        div_d = div_q;
        err_d = frame_bad;
        if (div_req) begin
            div_d = req_data;
        end
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            div_q <= '0;
            err_q <= 1'b0;
        end else begin
            div_q <= div_d;
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Confreg sequencer
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] conf_q, conf_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] guard_q, guard_d;
    logic       quiet_q, quiet_d;

    // The new word lands on entry to COMMIT; COMMIT is the one extra quiet
    // cycle before outputs are released, and accepts requests like IDLE.
    always_comb begin
        state_d   = state_q;
        conf_d    = conf_q;
        pending_d = pending_q;
        guard_d   = guard_q;
        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cfg_req) begin
                    if (req_data[7:5] == conf_q[7:5]) begin
                        conf_d = req_data;
                    end else begin
                        pending_d = req_data;
                        guard_d   = GUARD_LOAD;
                        state_d   = ST_QUIET;
                    end
                end
            end
            ST_QUIET: begin
                if (cfg_req) begin
                    pending_d = req_data;
                    guard_d   = GUARD_LOAD;
                end else if (guard_q == 8'd0) begin
                    conf_d  = pending_q;
                    state_d = ST_COMMIT;
                end else begin
                    guard_d = guard_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        quiet_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            conf_q    <= CONF_RST;
            pending_q <= '0;
            guard_q   <= '0;
            quiet_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            conf_q    <= conf_d;
            pending_q <= pending_d;
            guard_q   <= guard_d;
            quiet_q   <= quiet_d;
        end
    end

    assign conf_word  = conf_q;
    assign major_mode = conf_q[7:5];
    assign divisor    = div_q;
    assign mode_quiet = quiet_q;
    assign busy       = (state_q != ST_IDLE);
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_fpga_conf_ctrl.sv
// Directed bench for fpga_conf_ctrl: one instance with the default guard and
// one with a long guard so frames can land while a switch is still quiet.
module tb_fpga_conf_ctrl;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic spck = 1'b0;
    logic mosi = 1'b0;
    logic ncs = 1'b1;

    logic [7:0] conf_a, div_a, conf_b, div_b;
    logic [2:0] mm_a, mm_b;
    logic       quiet_a, busy_a, err_a, quiet_b, busy_b, err_b;

    localparam int GB = 255;

    always #37 clk = ~clk;

    fpga_conf_ctrl #(.GUARD_CYCLES(16), .SYNC_STAGES(2)) dut (
        .ck_1356meg(clk), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .conf_word(conf_a), .major_mode(mm_a), .divisor(div_a),
        .mode_quiet(quiet_a), .busy(busy_a), .cmd_err(err_a)
    );

    fpga_conf_ctrl #(.GUARD_CYCLES(GB), .SYNC_STAGES(2)) dut_g (
        .ck_1356meg(clk), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .conf_word(conf_b), .major_mode(mm_b), .divisor(div_b),
        .mode_quiet(quiet_b), .busy(busy_b), .cmd_err(err_b)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int t_rel = 0;
    int tq = 0;
    int tr = 0;
    int quiet_hits = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (quiet_a) quiet_hits++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic frame_begin();
        ncs = 1'b1;
        wait_neg(6);
        ncs = 1'b0;
        wait_neg(4);
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = (i < 16) ? w[15-i] : 1'b0;
            wait_neg(2);
            spck = 1'b1;
            wait_neg(4);
            spck = 1'b0;
            wait_neg(2);
        end
    endtask

    task automatic frame_end();
        wait_neg(3);
        ncs   = 1'b1;
        t_rel = cyc;
    endtask

    task automatic send_frame(input logic [15:0] w, input int n);
        frame_begin();
        send_bits(w, n);
        frame_end();
    endtask

    initial begin
        // reset values
        wait_neg(3);
        check("rst_conf", conf_a, 8'hE0);
        check("rst_mm", mm_a, 3'd7);
        check("rst_div", div_a, 8'h00);
        check("rst_quiet", quiet_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        nreset = 1'b1;
        wait_neg(4);

        // divisor frame, no quiet interval
        quiet_hits = 0;
        send_frame(16'h2095, 16);
        wait_until(t_rel + 2);
        check("div_early", div_a, 8'h00);
        wait_until(t_rel + 3);
        check("div_set", div_a, 8'h95);
        check("div_err", err_a, 1'b0);
        wait_neg(2);
        check("div_noquiet", quiet_hits, 0);

        // major-mode switch 111 -> 010
        send_frame(16'h1041, 16);
        wait_until(t_rel + 2);
        check("sw_prequiet", quiet_a, 1'b0);
        quiet_hits = 0;
        wait_until(t_rel + 18);
        check("sw_conf_hold", conf_a, 8'hE0);
        check("sw_busy", busy_a, 1'b1);
        wait_until(t_rel + 19);
        check("sw_conf_new", conf_a, 8'h41);
        check("sw_quiet_commit", quiet_a, 1'b1);
        wait_until(t_rel + 20);
        check("sw_quiet_end", quiet_a, 1'b0);
        check("sw_busy_end", busy_a, 1'b0);
        check("sw_mm", mm_a, 3'd2);
        check("sw_quiet_len", quiet_hits, 17);

        // same-mode update, immediate
        quiet_hits = 0;
        send_frame(16'h1040, 16);
        wait_until(t_rel + 2);
        check("same_early", conf_a, 8'h41);
        wait_until(t_rel + 3);
        check("same_conf", conf_a, 8'h40);
        wait_neg(2);
        check("same_noquiet", quiet_hits, 0);

        // short and long frames
        send_frame(16'h2055, 15);
        wait_until(t_rel + 3);
        check("f15_err", err_a, 1'b1);
        check("f15_div", div_a, 8'h95);
        wait_until(t_rel + 4);
        check("f15_err_width", err_a, 1'b0);
        send_frame(16'h2055, 17);
        wait_until(t_rel + 3);
        check("f17_err", err_a, 1'b1);
        check("f17_div", div_a, 8'h95);
        check("f17_conf", conf_a, 8'h40);
        wait_until(t_rel + 4);
        check("f17_err_width", err_a, 1'b0);

        // unknown opcode ignored
        send_frame(16'h3077, 16);
        wait_until(t_rel + 3);
        check("op3_err", err_a, 1'b0);
        check("op3_div", div_a, 8'h95);
        check("op3_conf", conf_a, 8'h40);

        // asynchronous reset mid-switch
        send_frame(16'h1081, 16);
        wait_until(t_rel + 8);
        check("mid_quiet", quiet_a, 1'b1);
        #5 nreset = 1'b0;
        #1;
        check("arst_conf", conf_a, 8'hE0);
        check("arst_quiet", quiet_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        check("arst_div", div_a, 8'h00);
        check("arst_mm", mm_a, 3'd7);

        // release reset with ncs already low: frame starts from bit 0
        ncs = 1'b0;
        wait_neg(3);
        nreset = 1'b1;
        wait_neg(4);
        send_bits(16'h2001, 16);
        frame_end();
        wait_until(t_rel + 2);
        check("rel_div_early", div_a, 8'h00);
        wait_until(t_rel + 3);
        check("rel_div", div_a, 8'h01);
        check("rel_err", err_a, 1'b0);
        check("rel_div_g", div_b, 8'h01);

        // long guard: divisor during QUIET leaves the guard alone
        send_frame(16'h1041, 16);
        tq = t_rel;
        wait_until(tq + 3);
        check("g_quiet", quiet_b, 1'b1);
        send_frame(16'h2033, 16);
        wait_until(t_rel + 3);
        check("g_div", div_b, 8'h33);
        check("g_div_quiet", quiet_b, 1'b1);
        check("g_div_conf", conf_b, 8'hE0);
        wait_until(tq + 2 + GB);
        check("g_conf_hold", conf_b, 8'hE0);
        wait_until(tq + 3 + GB);
        check("g_conf_new", conf_b, 8'h41);
        check("g_quiet_commit", quiet_b, 1'b1);
        wait_until(tq + 4 + GB);
        check("g_quiet_end", quiet_b, 1'b0);
        check("g_busy_end", busy_b, 1'b0);

        // long guard: confreg during QUIET restarts the guard
        send_frame(16'h1081, 16);
        tq = t_rel;
        wait_until(tq + 3);
        check("rs_quiet", quiet_b, 1'b1);
        send_frame(16'h1060, 16);
        tr = t_rel;
        wait_until(tq + 3 + GB);
        check("rs_no_old_commit", conf_b, 8'h41);
        check("rs_still_quiet", quiet_b, 1'b1);
        wait_until(tr + 2 + GB);
        check("rs_conf_hold", conf_b, 8'h41);
        wait_until(tr + 3 + GB);
        check("rs_conf_new", conf_b, 8'h60);
        check("rs_mm", mm_b, 3'd3);
        wait_until(tr + 4 + GB);
        check("rs_quiet_end", quiet_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
